mod_n_seq_checker: RTL

MOD_N_SEQ_CHECKER -- requirements
Module: mod_n_seq_checker

---
 rtl/mod_n_pkg.sv | 33 +++
 rtl/mod_n_seq_checker.sv | 103 ++++++++++
 2 files changed

// File: rtl/mod_n_pkg.sv
// Shared types and helpers for the mod-N sequence checker.
// Holds the tracker state encoding and the next-count model.
package mod_n_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    RESYNC = 2'd2
  } state_e;

  function automatic int next_exp(
    input int   q,
    input logic en,
    input logic up,
    input int   n
  );
    if (!en) return q;
    if (up) return (q == n - 1) ? 0 : q + 1;
    return (q == 0) ? n - 1 : q - 1;
  endfunction

  function automatic logic wraps(
    input int   q,
    input logic en,
    input logic up,
    input int   n
  );
    if (!en) return 1'b0;
    if (up) return q == n - 1;
    return q == 0;
  endfunction

endpackage

// File: rtl/mod_n_seq_checker.sv
// Observes a mod-N up/down counter and flags sequence,
// range and wrap events with registered pulses.
module mod_n_seq_checker
  import mod_n_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int N     = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_up_down,
  input  logic [WIDTH-1:0] i_Q,
  input  logic             i_clr,
  output logic             o_err,
  output logic             o_range_err,
  output logic             o_wrap,
  output logic             o_err_sticky,
  output logic [7:0]       o_err_cnt,
  output logic             o_locked
);

  localparam logic [WIDTH:0] N_W = (WIDTH + 1)'(N);

  state_e           state;
  state_e           state_nxt;
  logic [WIDTH-1:0] q_prev;
  logic             en_prev;
  logic             ud_prev;

  logic [WIDTH-1:0] exp_q;
  logic             range_hit;
  logic             mismatch;
  logic             wrapped;
  logic             err_nxt;
  logic             rng_nxt;
  logic             wrap_nxt;
  logic             ev;

  always_comb begin
    exp_q     = WIDTH'(next_exp(int'(q_prev), en_prev, ud_prev, N));
    wrapped   = wraps(int'(q_prev), en_prev, ud_prev, N);
    range_hit = {1'b0, i_Q} >= N_W;
    mismatch  = range_hit || (i_Q != exp_q);
    state_nxt = state;
    err_nxt   = 1'b0;
    wrap_nxt  = 1'b0;
    unique case (state)
      IDLE:   state_nxt = TRACK;
      RESYNC: state_nxt = TRACK;
      TRACK: begin
        if (mismatch) begin
          state_nxt = RESYNC;
          err_nxt   = 1'b1;
        end else begin
          wrap_nxt  = wrapped;
        end
      end
      default: state_nxt = IDLE;
    endcase
    rng_nxt = range_hit;
    // Clear wins over anything detected on the same sample
    if (i_clr) begin
      state_nxt = IDLE;
      err_nxt   = 1'b0;
      rng_nxt   = 1'b0;
      wrap_nxt  = 1'b0;
    end
    ev = err_nxt || rng_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      q_prev       <= '0;
      en_prev      <= 1'b0;
      ud_prev      <= 1'b0;
      o_err        <= 1'b0;
      o_range_err  <= 1'b0;
      o_wrap       <= 1'b0;
      o_err_sticky <= 1'b0;
      o_err_cnt    <= 8'd0;
      o_locked     <= 1'b0;
    end else begin
      state       <= state_nxt;
      q_prev      <= i_Q;
      en_prev     <= i_en;
      ud_prev     <= i_up_down;
      o_err       <= err_nxt;
      o_range_err <= rng_nxt;
      o_wrap      <= wrap_nxt;
      o_locked    <= state_nxt == TRACK;
      if (i_clr) begin
        o_err_sticky <= 1'b0;
        o_err_cnt    <= 8'd0;
      end else if (ev) begin
        o_err_sticky <= 1'b1;
        if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
      end
    end
  end

endmodule
